// File: rtl/dl_bank_scheduler.sv
// Ping-pong bank scheduler for the downlink frame RAM: allocates one of two
// banks per frame, queues completed frames oldest-first, reclaims on read/timeout/clear.
module dl_bank_scheduler #(
  parameter int DEPTH_LOG2 = 6,
  parameter int TIMEOUT    = 20000,
  parameter int CNT_W      = 8
) (
  input  logic                  Clk10MHz,
  input  logic                  Rst,
  input  logic                  DlDataRevEnable,
  input  logic                  wr_start,
  input  logic                  wr_word_en,
  input  logic                  wr_done,
  output logic                  wr_grant,
  output logic [DEPTH_LOG2:0]   wr_addr,
  output logic                  wr_en,
  output logic                  wr_drop,
  output logic                  rd_valid,
  output logic                  rd_bank,
  output logic [DEPTH_LOG2:0]   rd_len,
  input  logic                  rd_ready,
  input  logic                  rd_done,
  output logic                  timeout_pulse,
  output logic [CNT_W-1:0]      drop_cnt
);
  localparam int AW = DEPTH_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FREE, WRITING, FULL, READING} bst_t;

  bst_t          bst   [2];
  bst_t          n_bst [2];
  logic [AW-1:0] len   [2];
  logic [AW-1:0] n_len [2];
  logic          q0, q1, n_q0, n_q1;
  logic [1:0]    qcnt, n_qcnt;
  logic          bank, n_bank, last, n_last, ovf, n_ovf, n_grant;
  logic [AW-1:0] idx, n_idx, len_w;
  logic [TW-1:0] timer, n_timer;
  logic          ev_drop, ev_to, pick, n_rd_valid;
  logic          clr;

  assign clr     = Rst | ~DlDataRevEnable;
  assign wr_en   = wr_word_en & wr_grant & ~idx[DEPTH_LOG2];
  assign wr_addr = wr_grant ? {bank, idx[DEPTH_LOG2-1:0]} : '0;

  always_comb begin
    n_bst   = bst;
    n_len   = len;
    n_q0    = q0;
    n_q1    = q1;
    n_qcnt  = qcnt;
    n_grant = wr_grant;
    n_bank  = bank;
    n_idx   = idx;
    n_ovf   = ovf;
    n_last  = last;
    ev_drop = 1'b0;
    ev_to   = 1'b0;
    pick    = 1'b0;
    len_w   = '0;

    if (rd_done)
      for (int b = 0; b < 2; b++)
        if (bst[b] == READING) n_bst[b] = FREE;

    if (rd_valid && rd_ready) begin
      n_bst[rd_bank] = READING;
      n_q0   = q1;
      n_qcnt = qcnt - 2'd1;
    end

    if (wr_grant) begin
      if (wr_done) begin
        // A word arriving alongside wr_done still belongs to the frame.
        len_w = wr_en ? idx + 1'b1 : idx;
        if (len_w != '0) begin
          n_bst[bank] = FULL;
          n_len[bank] = len_w;
          if (n_qcnt == 2'd0) n_q0 = bank;
          else                n_q1 = bank;
          n_qcnt = n_qcnt + 2'd1;
        end else begin
          n_bst[bank] = FREE;
        end
        n_grant = 1'b0;
      end else if (!wr_start && !wr_word_en && timer == TW'(TIMEOUT - 1)) begin
        n_bst[bank] = FREE;
        n_grant     = 1'b0;
        ev_to       = 1'b1;
      end else if (wr_en) begin
        n_idx = idx + 1'b1;
      end else if (wr_word_en && !ovf) begin
        ev_drop = 1'b1;
        n_ovf   = 1'b1;
      end
    end

    if (wr_start) begin
      if (n_grant) begin
        n_idx = '0;
        n_ovf = 1'b0;
      end else if (n_bst[0] == FREE || n_bst[1] == FREE) begin
        if (n_bst[0] == FREE && n_bst[1] == FREE) pick = ~last;
        else                                      pick = (n_bst[0] == FREE) ? 1'b0 : 1'b1;
        n_bst[pick] = WRITING;
        n_grant = 1'b1;
        n_bank  = pick;
        n_idx   = '0;
        n_ovf   = 1'b0;
        n_last  = pick;
      end else begin
        ev_drop = 1'b1;
      end
    end

    n_timer = (n_grant && !wr_start && !wr_word_en) ? timer + 1'b1 : '0;

    // Only one bank may be in the reader at a time.
    n_rd_valid = (n_qcnt != 2'd0) && (n_bst[n_q0] == FULL) &&
                 (n_bst[0] != READING) && (n_bst[1] != READING);
  end

  always_ff @(posedge Clk10MHz) begin
    if (clr) begin
      bst[0]        <= FREE;
      bst[1]        <= FREE;
      len[0]        <= '0;
      len[1]        <= '0;
      q0            <= 1'b0;
      q1            <= 1'b0;
      qcnt          <= 2'd0;
      wr_grant      <= 1'b0;
      bank          <= 1'b0;
      idx           <= '0;
      ovf           <= 1'b0;
      last          <= 1'b1;
      timer         <= '0;
      wr_drop       <= 1'b0;
      timeout_pulse <= 1'b0;
      drop_cnt      <= '0;
      rd_valid      <= 1'b0;
      rd_bank       <= 1'b0;
      rd_len        <= '0;
    end else begin
      bst           <= n_bst;
      len           <= n_len;
      q0            <= n_q0;
      q1            <= n_q1;
      qcnt          <= n_qcnt;
      wr_grant      <= n_grant;
      bank          <= n_bank;
      idx           <= n_idx;
      ovf           <= n_ovf;
      last          <= n_last;
      timer         <= n_timer;
      wr_drop       <= ev_drop;
      timeout_pulse <= ev_to;
      if (ev_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      rd_valid      <= n_rd_valid;
      rd_bank       <= n_rd_valid ? n_q0 : 1'b0;
      rd_len        <= n_rd_valid ? n_len[n_q0] : '0;
    end
  end
endmodule

// File: tb/tb_dl_bank_scheduler.sv
// Directed bench for dl_bank_scheduler with a short timeout.
module tb_dl_bank_scheduler;
  localparam int TO = 50;

  logic       Clk10MHz = 1'b0;
  logic       Rst = 1'b1, DlDataRevEnable = 1'b1;
  logic       wr_start = 1'b0, wr_word_en = 1'b0, wr_done = 1'b0;
  logic       rd_ready = 1'b0, rd_done = 1'b0;
  logic       wr_grant, wr_en, wr_drop, rd_valid, rd_bank, timeout_pulse;
  logic [6:0] wr_addr, rd_len;
  logic [7:0] drop_cnt;

  int total = 0, bad = 0;
  int ens, drops, tos, rv;

  dl_bank_scheduler #(.DEPTH_LOG2(6), .TIMEOUT(TO), .CNT_W(8)) dut (
    .Clk10MHz(Clk10MHz), .Rst(Rst), .DlDataRevEnable(DlDataRevEnable),
    .wr_start(wr_start), .wr_word_en(wr_word_en), .wr_done(wr_done),
    .wr_grant(wr_grant), .wr_addr(wr_addr), .wr_en(wr_en), .wr_drop(wr_drop),
    .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_len(rd_len),
    .rd_ready(rd_ready), .rd_done(rd_done),
    .timeout_pulse(timeout_pulse), .drop_cnt(drop_cnt)
  );

  always #5 Clk10MHz = ~Clk10MHz;

  task automatic step();
    @(posedge Clk10MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic words(input int n);
    for (int i = 0; i < n; i++) begin
      wr_word_en = 1'b1;
      step();
    end
    wr_word_en = 1'b0;
  endtask

  task automatic pulse_start();
    wr_start = 1'b1; step(); wr_start = 1'b0;
  endtask

  task automatic pulse_done();
    wr_done = 1'b1; step(); wr_done = 1'b0;
  endtask

  initial begin
    step(); step();
    Rst = 1'b0;
    chk("rst_grant", wr_grant, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Frame 1: 10 words into bank 0
    pulse_start();
    chk("f1_grant", wr_grant, 1);
    for (int i = 0; i < 10; i++) begin
      wr_word_en = 1'b1;
      #1;
      chk("f1_wr_en", wr_en, 1);
      chk("f1_addr", wr_addr, i);
      step();
    end
    wr_word_en = 1'b0;
    pulse_done();
    chk("f1_grant_off", wr_grant, 0);
    chk("f1_rd_valid", rd_valid, 1);
    chk("f1_rd_bank", rd_bank, 0);
    chk("f1_rd_len", rd_len, 10);

    // Frame 2: 20 words into bank 1, reader stalled
    pulse_start();
    wr_word_en = 1'b1; #1;
    chk("f2_addr0", wr_addr, 64);
    words(20);
    pulse_done();
    chk("f2_head_bank", rd_bank, 0);
    chk("f2_head_len", rd_len, 10);
    pulse_start();
    chk("f3_drop", wr_drop, 1);
    chk("f3_drop_cnt", drop_cnt, 1);
    chk("f3_no_grant", wr_grant, 0);
    wr_word_en = 1'b1; #1;
    chk("nogrant_wr_en", wr_en, 0);
    step(); wr_word_en = 1'b0;
    chk("drop_one_cycle", wr_drop, 0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("accept_clears_valid", rd_valid, 0);
    step();
    chk("reading_blocks_valid", rd_valid, 0);
    rd_done = 1'b1; step(); rd_done = 1'b0;
    chk("second_valid", rd_valid, 1);
    chk("second_bank", rd_bank, 1);
    chk("second_len", rd_len, 20);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    rd_done = 1'b1; step(); rd_done = 1'b0;
    chk("queue_empty", rd_valid, 0);

    // 70-word frame: truncated at 64 with one drop
    pulse_start();
    ens = 0; drops = 0;
    for (int i = 0; i < 70; i++) begin
      wr_word_en = 1'b1; #1;
      if (wr_en) ens++;
      if (i == 63) chk("ovf_last_addr", wr_addr, 63);
      step();
      if (wr_drop) drops++;
    end
    wr_word_en = 1'b0;
    step(); if (wr_drop) drops++;
    chk("ovf_wr_en_count", ens, 64);
    chk("ovf_drop_count", drops, 1);
    chk("ovf_drop_cnt", drop_cnt, 2);
    pulse_done();
    chk("ovf_rd_len", rd_len, 64);
    chk("ovf_rd_bank", rd_bank, 0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    rd_done = 1'b1; step(); rd_done = 1'b0;

    // Timeout: 3 words then silence, lands in bank 1
    pulse_start();
    chk("to_bank1", wr_addr, 64);
    words(3);
    tos = 0; rv = 0;
    for (int i = 0; i < TO + 10; i++) begin
      step();
      if (timeout_pulse) tos++;
      if (rd_valid) rv = 1;
    end
    chk("to_pulses", tos, 1);
    chk("to_grant", wr_grant, 0);
    chk("to_no_valid", rv, 0);
    pulse_start();
    chk("after_to_bank0", wr_addr, 0);
    words(1);
    pulse_done();
    pulse_start();
    chk("after_to_bank1", wr_addr, 64);
    chk("after_to_no_drop", wr_drop, 0);

    // Both busy; rd_done and wr_start together grant the freed bank
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    words(2);
    pulse_done();
    chk("busy_no_valid", rd_valid, 0);
    wr_start = 1'b1; rd_done = 1'b1; step(); wr_start = 1'b0; rd_done = 1'b0;
    chk("bypass_grant", wr_grant, 1);
    chk("bypass_bank0", wr_addr, 0);
    chk("bypass_no_drop", wr_drop, 0);
    chk("bypass_valid", rd_valid, 1);
    chk("bypass_rd_bank", rd_bank, 1);
    chk("bypass_rd_len", rd_len, 2);

    // Soft clear mid-frame with bank 1 FULL
    words(2);
    DlDataRevEnable = 1'b0; step(); DlDataRevEnable = 1'b1;
    chk("clr_grant", wr_grant, 0);
    chk("clr_valid", rd_valid, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    pulse_start();
    chk("clr_grant_again", wr_grant, 1);
    chk("clr_bank0", wr_addr, 0);

    // Fill both banks, then saturate the drop counter
    words(1);
    pulse_done();
    pulse_start();
    words(1);
    pulse_done();
    wr_start = 1'b1;
    for (int i = 0; i < 260; i++) step();
    wr_start = 1'b0;
    chk("sat_drop_cnt", drop_cnt, 255);
    chk("sat_no_grant", wr_grant, 0);
    pulse_done();
    chk("done_nogrant_valid", rd_valid, 1);
    chk("done_nogrant_bank", rd_bank, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
